freelist_ckpt: RTL
==================

# freelist_ckpt

Parametrised physical-register free list for the R10K rename stage. Replaces the fixed 3-way free list with one that supports:
- configurable register-file size and dispatch/retire width;
- multiple branch checkpoints, so recovery restores the list to the state at any in-flight branch instead of only the most recent one.

It sits between dispatch (allocation) and the ROB retire stage (reclamation). Its checkpoints are indexed by the same branch tags as the map-table checkpoints.

## Interface
Parameters:
- NUM_PR, 64: physical registers.
- NUM_AR, 32: architectural registers. PRs 0..NUM_AR-1 are never in the list at reset.
- WAYS, 3: allocation ports and free ports per cycle.
- NUM_CKPT, 4: branch checkpoints.
- Derived:
  - FL_DEPTH = NUM_PR-NUM_AR; must be a power of two.
  - PR_W = $clog2(NUM_PR).
  - PTR_W = $clog2(FL_DEPTH)+1, which includes the wrap bit.
  - CKPT_W = $clog2(NUM_CKPT).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- alloc_req  in  WAYS  dispatch requests. Must be thermometer form (contiguous from bit 0).
- alloc_pr  out  WAYS×PR_W  PR offered on each way.
- alloc_valid  out  WAYS  alloc_pr[i] is usable.
- free_en  in  WAYS  retire frees; any bit pattern allowed.
- free_pr  in  WAYS×PR_W  PRs being freed.
- ckpt_save  in  1  snapshot request.
- ckpt_id  in  CKPT_W  checkpoint slot to write.
- rec_en  in  1  mispredict recovery.
- rec_id  in  CKPT_W  checkpoint slot to restore.
- free_count  out  PTR_W  entries currently free.
- empty  out  1  free_count==0.
- full  out  1  free_count==FL_DEPTH.
- err_overflow  out  1  sticky error flag.

## Operation
- Storage is a circular buffer fl[FL_DEPTH] of PR tags with head and tail pointers, each PTR_W wide.
  - free_count = tail-head, computed modulo 2^PTR_W.
- Reset (rst_n=0 at posedge):
  - fl[i]=NUM_AR+i.
  - head=0; tail=FL_DEPTH, i.e. wrap bit set, so the list starts full.
  - All checkpoints=0; err_overflow=0.
- Allocation offer: alloc_pr[i]=fl[(head+i) mod FL_DEPTH]; alloc_valid[i]=(free_count>i).
- Number of PRs allocated: n_alloc=popcount(alloc_req & alloc_valid).
  - A requested way with alloc_valid=0 is not consumed; dispatch must stall it.
- Frees:
  - Set bits of free_en are compacted in ascending index order.
  - They are written to fl[tail], fl[tail+1], and so on.
  - tail advances by popcount(free_en).
- Checkpoint save (ckpt_save=1, rec_en=0): ckpt[ckpt_id] = head + n_alloc, i.e. the head after this cycle's allocations, so it includes the branch's own destination.
- Recovery (rec_en=1):
  - head = ckpt[rec_id] at the next edge.
  - alloc_req is ignored that cycle (n_alloc=0).
  - ckpt_save is ignored that cycle.
  - Same-cycle frees still advance tail.
  - tail is never restored: PRs freed after the checkpoint belong to older, retired instructions.
- Overflow: if free_count + popcount(free_en) > FL_DEPTH:
  - err_overflow is set and stays set until reset;
  - tail saturates at head+FL_DEPTH;
  - excess frees are dropped.
- Allocation and free in the same cycle are independent. A PR freed this cycle is never offered this cycle; there is no bypass.

## Timing
- alloc_pr, alloc_valid, free_count, empty and full are combinational from registered state only. There are no combinational paths from any input.
- Free-to-reuse latency is one cycle: a PR freed at edge k is offerable after edge k.
- Recovery takes effect at the edge where rec_en=1. Outputs in the following cycle reflect the restored head.
- Reset mid-operation discards all pointers and checkpoints in one cycle.
- Outputs during and immediately after reset: alloc_pr = NUM_AR..NUM_AR+WAYS-1; alloc_valid all 1; free_count=FL_DEPTH; full=1; empty=0.

## Structure
- Add constants FL_DEPTH, PTR_W and CKPT_W, and typedef fl_ptr_t (logic [PTR_W-1:0]), to sys_defs.svh, next to `SYS_PHYS_REG_ADDR_WIDTH.
- Add sub-module fl_compact: a WAYS-wide prefix-popcount compactor that maps a valid mask to write offsets. It is used for the free path; the allocation path is a plain popcount.
- Checkpoints are a small register array inside freelist_ckpt.
- Include a bound assertion that flags non-thermometer alloc_req.

## Test plan
All scenarios use the defaults: NUM_PR=64, NUM_AR=32, WAYS=3, NUM_CKPT=4.
- Reset: rst_n low for 1 edge -> alloc_pr=32,33,34; alloc_valid=111; free_count=32; full=1; err_overflow=0.
- Allocate: alloc_req=111 for 2 cycles -> alloc_pr=38,39,40; free_count=26. Then alloc_req=011 -> next cycle alloc_pr=40,41,42; free_count=24.
- Free ordering: drain the list to empty (alloc_valid=000, empty=1; alloc_req=111 changes nothing). Then free_en=101 with free_pr={9,x,5} -> next cycle alloc_pr[0]=5, alloc_pr[1]=9, alloc_valid=011, free_count=2.
- Checkpoint/recover: from reset, alloc_req=001 with ckpt_save=1, ckpt_id=1. Then alloc_req=111 for 3 cycles. Then rec_en=1, rec_id=1 with alloc_req=111 -> next cycle alloc_pr=33,34,35; free_count=31.
- Simultaneous events: with free_count=20, apply rec_en=1 (checkpoint head giving 25 free), ckpt_save=1 and free_en=111 -> free_count=28; the checkpoint slot is unchanged.
- Overflow: at full, free_en=001 -> err_overflow=1 and stays 1; free_count stays 32. Then rst_n low -> err_overflow=0.

Source files
------------

// File: rtl/freelist_ckpt_pkg.sv
// Shared constants and helpers for the checkpointed physical-register free list.
// Holds the default configuration (64 PRs, 32 ARs, 3 ways, 4 checkpoints), the
// derived free-list pointer type, and a thermometer-mask check used by assertions.
package freelist_ckpt_pkg;

  localparam int unsigned DEF_NUM_PR   = 64;
  localparam int unsigned DEF_NUM_AR   = 32;
  localparam int unsigned DEF_WAYS     = 3;
  localparam int unsigned DEF_NUM_CKPT = 4;

  localparam int unsigned DEF_FL_DEPTH = DEF_NUM_PR - DEF_NUM_AR;
  // Pointer width carries one extra wrap bit so full and empty are distinguishable.
  localparam int unsigned DEF_PTR_W    = $clog2(DEF_FL_DEPTH) + 1;
  localparam int unsigned DEF_CKPT_W   = $clog2(DEF_NUM_CKPT);

  typedef logic [DEF_PTR_W-1:0] fl_ptr_t;

  // True when v is of the form 0..01..1 (contiguous set bits starting at bit 0).
  function automatic logic is_thermo(logic [31:0] v);
    return (v & (v + 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/fl_compact.sv
// Prefix-popcount compactor.
// Maps a valid mask to per-way write offsets so set bits pack densely in
// ascending index order.
// Ports:
//   valid  in   WAYS        mask of ways carrying data
//   offset out  WAYS x OFF_W number of set bits below each way
//   total  out  OFF_W       popcount of valid
module fl_compact
  import freelist_ckpt_pkg::*;
#(
  parameter int unsigned WAYS  = DEF_WAYS,
  parameter int unsigned OFF_W = DEF_PTR_W
) (
  input  logic [WAYS-1:0]            valid,
  output logic [WAYS-1:0][OFF_W-1:0] offset,
  output logic [OFF_W-1:0]           total
);

  logic [OFF_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < WAYS; i++) begin
      offset[i] = acc;
      acc       = acc + OFF_W'(valid[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/freelist_ckpt.sv
// Physical-register free list with multiple branch checkpoints.
// Circular buffer of PR tags; head advances on allocation, tail on retire frees.
// Checkpoints snapshot the head so a mispredict can rewind allocation to any
// in-flight branch. All outputs depend only on registered state.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   alloc_req/pr/valid       dispatch allocation (thermometer request)
//   free_en/free_pr          retire frees, compacted in ascending way order
//   ckpt_save/ckpt_id        snapshot post-allocation head into a slot
//   rec_en/rec_id            restore head from a slot
//   free_count/empty/full    occupancy status
//   err_overflow             sticky: more frees than free slots were presented
module freelist_ckpt
  import freelist_ckpt_pkg::*;
#(
  parameter int unsigned NUM_PR   = DEF_NUM_PR,
  parameter int unsigned NUM_AR   = DEF_NUM_AR,
  parameter int unsigned WAYS     = DEF_WAYS,
  parameter int unsigned NUM_CKPT = DEF_NUM_CKPT,
  localparam int unsigned FL_DEPTH = NUM_PR - NUM_AR,
  localparam int unsigned PR_W     = $clog2(NUM_PR),
  localparam int unsigned PTR_W    = $clog2(FL_DEPTH) + 1,
  localparam int unsigned CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WAYS-1:0]            alloc_req,
  output logic [WAYS-1:0][PR_W-1:0]  alloc_pr,
  output logic [WAYS-1:0]            alloc_valid,
  input  logic [WAYS-1:0]            free_en,
  input  logic [WAYS-1:0][PR_W-1:0]  free_pr,
  input  logic                       ckpt_save,
  input  logic [CKPT_W-1:0]          ckpt_id,
  input  logic                       rec_en,
  input  logic [CKPT_W-1:0]          rec_id,
  output logic [PTR_W-1:0]           free_count,
  output logic                       empty,
  output logic                       full,
  output logic                       err_overflow
);

  localparam int unsigned IDX_W = PTR_W - 1;

  logic [PR_W-1:0]  fl_q   [FL_DEPTH];
  logic [PTR_W-1:0] ckpt_q [NUM_CKPT];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic             err_q, err_d;

  logic [WAYS-1:0][PTR_W-1:0] free_off;
  logic [WAYS-1:0][IDX_W-1:0] wr_idx;
  logic [PTR_W-1:0]           n_free, n_accept, n_alloc, space;
  logic [WAYS-1:0]            grant;

  assign free_count   = tail_q - head_q;
  assign empty        = free_count == '0;
  assign full         = free_count == PTR_W'(FL_DEPTH);
  assign err_overflow = err_q;

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    assign rd_ptr         = head_q + PTR_W'(i);
    assign alloc_pr[i]    = fl_q[rd_ptr[IDX_W-1:0]];
    assign alloc_valid[i] = 32'(free_count) > i;
    assign wr_ptr         = tail_q + free_off[i];
    assign wr_idx[i]      = wr_ptr[IDX_W-1:0];
  end

  fl_compact #(
    .WAYS  (WAYS),
    .OFF_W (PTR_W)
  ) u_compact (
    .valid  (free_en),
    .offset (free_off),
    .total  (n_free)
  );

  always_comb begin
    // Slots between tail and head+FL_DEPTH that may take a freed tag this cycle.
    space = PTR_W'(FL_DEPTH) - free_count;
    grant = rec_en ? '0 : (alloc_req & alloc_valid);
    n_alloc = '0;
    for (int i = 0; i < WAYS; i++) begin
      n_alloc = n_alloc + PTR_W'(grant[i]);
    end
    if (n_free > space) begin
      n_accept = space;
      err_d    = 1'b1;
    end else begin
      n_accept = n_free;
      err_d    = err_q;
    end
    tail_d = tail_q + n_accept;
    // Tail is never rewound: frees after the checkpoint come from retired work.
    head_d = rec_en ? ckpt_q[rec_id] : head_q + n_alloc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= PTR_W'(FL_DEPTH);
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        ckpt_q[i] <= '0;
      end
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= PR_W'(NUM_AR + i);
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
      if (ckpt_save && !rec_en) begin
        ckpt_q[ckpt_id] <= head_q + n_alloc;
      end
      // Frees whose compacted offset lands past the saturation point are dropped.
      for (int i = 0; i < WAYS; i++) begin
        if (free_en[i] && (free_off[i] < space)) begin
          fl_q[wr_idx[i]] <= free_pr[i];
        end
      end
    end
  end

  alloc_req_thermo: assert property (@(posedge clk) disable iff (!rst_n)
    is_thermo(32'(alloc_req)));

endmodule
